// File: rtl/fft_pkg.sv
// Shared myFFT definitions: reader FSM encoding and the NFFT / scaling-width
// derivations used by both the FFT core and its output reader.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } fft_state_e;

  function automatic int fft_nfft(input int size_buffer);
    return 1 << size_buffer;
  endfunction

  // Bin width at the FFT output: input width grows by log2(NFFT) minus the
  // two bits the butterflies already absorb.
  function automatic int fft_out_width(input int data_fft_size, input int size_buffer);
    return data_fft_size + size_buffer - 2;
  endfunction

  function automatic int fft_scale_shift(input int size_buffer);
    return size_buffer - 2;
  endfunction

  function automatic int fft_round_bias(input int shift, input int round);
    return (round != 0 && shift > 0) ? (1 << (shift - 1)) : 0;
  endfunction

endpackage

// File: rtl/fft_scale_sat.sv
// Combinational round-half-up / arithmetic-shift / saturate of one FFT
// component from W_IN down to W_OUT bits.
module fft_scale_sat
  import fft_pkg::*;
#(
  parameter int W_IN  = 22,
  parameter int W_OUT = 16,
  parameter int SHIFT = 6,
  parameter int ROUND = 1
) (
  input  logic signed [W_IN-1:0]  din,
  output logic signed [W_OUT-1:0] dout
);

  localparam logic signed [W_IN:0] BIAS = (W_IN+1)'(fft_round_bias(SHIFT, ROUND));
  localparam logic signed [W_IN:0] MAXV = (W_IN+1)'((1 << (W_OUT - 1)) - 1);
  localparam logic signed [W_IN:0] MINV = ~MAXV;

  logic signed [W_IN:0] t;
  logic signed [W_IN:0] y;

  // One guard bit so the rounding bias cannot wrap the most positive input.
  always_comb begin
    t = $signed({din[W_IN-1], din}) + BIAS;
    y = t >>> SHIFT;
    if (y > MAXV)      dout = {1'b0, {(W_OUT-1){1'b1}}};
    else if (y < MINV) dout = {1'b1, {(W_OUT-1){1'b0}}};
    else               dout = y[W_OUT-1:0];
  end

endmodule

// File: rtl/fft_frame_reader.sv
// myFFT output consumer: captures one NFFT-bin frame (scaled on the way in),
// then streams it out over valid/ready in natural or fftshift order.
module fft_frame_reader
  import fft_pkg::*;
#(
  parameter int SIZE_BUFFER   = 8,
  parameter int SIZE_DATA_IN  = fft_out_width(16, SIZE_BUFFER),
  parameter int SIZE_DATA_OUT = 16,
  parameter int SHIFT         = fft_scale_shift(SIZE_BUFFER),
  parameter int ROUND         = 1,
  parameter int FFTSHIFT      = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fft_complete,
  input  logic [SIZE_DATA_IN-1:0]  fft_data_i,
  input  logic [SIZE_DATA_IN-1:0]  fft_data_q,
  output logic                     fft_ready_recive,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SIZE_DATA_OUT-1:0] out_data_i,
  output logic [SIZE_DATA_OUT-1:0] out_data_q,
  output logic [SIZE_BUFFER-1:0]   out_index,
  output logic                     out_last,
  output logic                     overflow,
  output logic [1:0]               state
);

  localparam int NFFT = fft_nfft(SIZE_BUFFER);
  localparam logic [SIZE_BUFFER-1:0] LAST_IDX = SIZE_BUFFER'(NFFT - 1);
  localparam logic [SIZE_BUFFER-1:0] XOR_MASK = (FFTSHIFT != 0) ? SIZE_BUFFER'(NFFT / 2) : '0;

  typedef struct packed {
    logic [SIZE_DATA_OUT-1:0] i;
    logic [SIZE_DATA_OUT-1:0] q;
  } iq_t;

  fft_state_e state_q, state_d;
  logic ready_q, ready_d, ovf_q, ovf_d;
  logic [SIZE_BUFFER-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic rd_done_q, rd_done_d;
  logic rv_q, rv_d;
  logic [SIZE_BUFFER-1:0] ram_idx_q, ram_idx_d;
  logic ram_last_q, ram_last_d;
  logic ov_q, ov_d, olast_q, olast_d;
  iq_t  od_q, od_d;
  logic [SIZE_BUFFER-1:0] oidx_q, oidx_d;

  iq_t mem [NFFT];
  iq_t ram_q, wr_data;
  logic [SIZE_DATA_OUT-1:0] sc_i, sc_q;
  logic accept, we, re, load;
  logic [SIZE_BUFFER-1:0] wr_addr, rd_addr;

  fft_scale_sat #(.W_IN(SIZE_DATA_IN), .W_OUT(SIZE_DATA_OUT), .SHIFT(SHIFT), .ROUND(ROUND))
    u_scale_i (.din(fft_data_i), .dout(sc_i));
  fft_scale_sat #(.W_IN(SIZE_DATA_IN), .W_OUT(SIZE_DATA_OUT), .SHIFT(SHIFT), .ROUND(ROUND))
    u_scale_q (.din(fft_data_q), .dout(sc_q));

  assign wr_data = '{i: sc_i, q: sc_q};

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) ram_q <= mem[rd_addr];
  end

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    rd_done_d  = rd_done_q;
    ovf_d      = ovf_q | (fft_complete & ~ready_q);
    accept     = fft_complete & ready_q;
    we         = 1'b0;
    re         = 1'b0;
    wr_addr    = wr_cnt_q;
    rd_addr    = rd_cnt_q ^ XOR_MASK;
    load       = rv_q & (~ov_q | out_ready);
    case (state_q)
      IDLE: if (accept) begin
        we       = 1'b1;
        wr_addr  = '0;
        wr_cnt_d = SIZE_BUFFER'(1);
        state_d  = CAPTURE;
      end
      CAPTURE: if (accept) begin
        we       = 1'b1;
        wr_cnt_d = wr_cnt_q + 1'b1;
        if (wr_cnt_q == LAST_IDX) state_d = DRAIN;
      end
      DRAIN: begin
        // Fetch whenever the RAM output stage is empty or drains this cycle.
        re = ~rd_done_q & (~rv_q | load);
        if (re) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (rd_cnt_q == LAST_IDX) rd_done_d = 1'b1;
        end
        if (ov_q & out_ready & olast_q) begin
          state_d   = IDLE;
          rd_cnt_d  = '0;
          rd_done_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d    = (state_d != DRAIN);
    rv_d       = re | (rv_q & ~load);
    ram_idx_d  = re ? rd_addr : ram_idx_q;
    ram_last_d = re ? (rd_cnt_q == LAST_IDX) : ram_last_q;
    ov_d       = load | (ov_q & ~out_ready);
    od_d       = load ? ram_q : od_q;
    oidx_d     = load ? ram_idx_q : oidx_q;
    olast_d    = load ? ram_last_q : olast_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      ovf_q      <= 1'b0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      rd_done_q  <= 1'b0;
      rv_q       <= 1'b0;
      ram_idx_q  <= '0;
      ram_last_q <= 1'b0;
      ov_q       <= 1'b0;
      od_q       <= '0;
      oidx_q     <= '0;
      olast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      ovf_q      <= ovf_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_done_q  <= rd_done_d;
      rv_q       <= rv_d;
      ram_idx_q  <= ram_idx_d;
      ram_last_q <= ram_last_d;
      ov_q       <= ov_d;
      od_q       <= od_d;
      oidx_q     <= oidx_d;
      olast_q    <= olast_d;
    end
  end

  assign fft_ready_recive = ready_q;
  assign out_valid        = ov_q;
  assign out_data_i       = od_q.i;
  assign out_data_q       = od_q.q;
  assign out_index        = oidx_q;
  assign out_last         = olast_q;
  assign overflow         = ovf_q;
  assign state            = state_q;

endmodule
